// File: rtl/host_io_pkg.sv
// host_io_pkg: shared constants for the host I/O sequencer and Data_RAM users.
// The state encoding is one-hot and is kept as plain constants so that
// older code can keep comparing against raw bit patterns.
package host_io_pkg;

  // Default word and address widths of the Data_RAM.
  localparam int DATA_W_DEF = 16;
  localparam int ADDR_W_DEF = 10;

  // Input frames land at the bottom of the RAM and results are read from
  // the upper half. Data_RAM users share these addresses.
  localparam int IN_BASE_DEF  = 0;
  localparam int OUT_BASE_DEF = 512;

  // One-hot sequencer state.
  localparam int ST_W = 5;
  typedef logic [ST_W-1:0] host_state_t;

  localparam host_state_t ST_RX           = 5'b00001;
  localparam host_state_t ST_COMPUTE      = 5'b00010;
  localparam host_state_t ST_TX_RD        = 5'b00100;
  localparam host_state_t ST_TX_WAIT_IDLE = 5'b01000;
  localparam host_state_t ST_TX_BUSY      = 5'b10000;

endpackage

// File: rtl/host_rx_timeout.sv
// host_rx_timeout: idle-cycle timer between received words of a frame.
// expire is combinational and is high on the TIMEOUT-th consecutive cycle
// with count_en set; the timer restarts from zero on clear or on expiry.
module host_rx_timeout #(
  parameter int TIMEOUT = 12500
) (
  input  logic Clk,
  input  logic Rst_n,
  input  logic clear,
  input  logic count_en,
  output logic expire
);

  localparam int TW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

  logic [TW-1:0] timer_reg;

  assign expire = count_en && !clear && (timer_reg == TW'(TIMEOUT - 1));

  // Count idle cycles; restart on any clear or on expiry.
  always_ff @(posedge Clk) begin
    if (!Rst_n || clear || expire) begin
      timer_reg <= '0;
    end else if (count_en) begin
      timer_reg <= timer_reg + 1'b1;
    end
  end

endmodule

// File: rtl/host_io_sequencer.sv
// host_io_sequencer: receives a frame of words into Data_RAM, runs one
// compute pass, then streams result words out through the UART TX.
// Optional feature macro: HOST_SEQ_CHECKSUM_EN -- each frame carries an
// extra trailing XOR word that must match before compute is started.
module host_io_sequencer
  import host_io_pkg::*;
#(
  parameter int DATA_W   = DATA_W_DEF,
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int N_IN     = 512,
  parameter int N_OUT    = 4,
  parameter int IN_BASE  = IN_BASE_DEF,
  parameter int OUT_BASE = OUT_BASE_DEF,
  parameter int RD_LAT   = 1,
  parameter int TIMEOUT  = 12500
) (
  input  logic              Clk,
  input  logic              Rst_n,
  input  logic              Rx_Valid,
  input  logic [DATA_W-1:0] Rx_Data,
  output logic              Wr_En,
  output logic [ADDR_W-1:0] Wr_Addr,
  output logic [DATA_W-1:0] Wr_Data,
  output logic              Rd_En,
  output logic [ADDR_W-1:0] Rd_Addr,
  input  logic [DATA_W-1:0] Rd_Data,
  output logic              Host_Owns_Ram,
  output logic              Compute_En,
  input  logic              Compute_Done,
  output logic [DATA_W-1:0] Tx_Data,
  output logic              Tx_Start,
  input  logic              Tx_Idle,
  output logic              Frame_Err,
  output logic [15:0]       Frame_Cnt
);

  // Counter must reach N_IN itself when a checksum word follows the data.
  localparam int CNT_W = ADDR_W + 1;
`ifdef HOST_SEQ_CHECKSUM_EN
  localparam int N_RX = N_IN + 1;
`else
  localparam int N_RX = N_IN;
`endif
  localparam logic [CNT_W-1:0]  LAST_RX  = CNT_W'(N_RX - 1);
  localparam logic [CNT_W-1:0]  LAST_OUT = CNT_W'(N_OUT - 1);
  localparam logic [ADDR_W-1:0] IN_A     = ADDR_W'(IN_BASE);
  localparam logic [ADDR_W-1:0] OUT_A    = ADDR_W'(OUT_BASE);

  host_state_t      state_reg;
  logic [CNT_W-1:0] cnt_reg;
  logic             phase_reg;   // TX_RD: read issued; TX_BUSY: UART went busy
  logic [1:0]       lat_reg;
  logic             tmo_expire;
  logic             last_rx;
  logic             sum_word;
  logic             sum_ok;

  assign last_rx = (cnt_reg == LAST_RX);

`ifdef HOST_SEQ_CHECKSUM_EN
  logic [DATA_W-1:0] xor_reg;

  assign sum_word = (cnt_reg == CNT_W'(N_IN));
  assign sum_ok   = (Rx_Data == xor_reg);

  // Running XOR of the data words of the frame being received.
  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      xor_reg <= '0;
    end else if (state_reg == ST_RX) begin
      if (Rx_Valid) begin
        xor_reg <= last_rx ? '0 : (xor_reg ^ Rx_Data);
      end else if (tmo_expire) begin
        xor_reg <= '0;
      end
    end
  end
`else
  assign sum_word = 1'b0;
  assign sum_ok   = 1'b1;
`endif

  host_rx_timeout #(
    .TIMEOUT (TIMEOUT)
  ) u_timeout (
    .Clk      (Clk),
    .Rst_n    (Rst_n),
    .clear    (Rx_Valid || (state_reg != ST_RX)),
    .count_en ((state_reg == ST_RX) && (cnt_reg != '0) && !Rx_Valid),
    .expire   (tmo_expire)
  );

  // Frame sequencing FSM; every output is registered.
  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      state_reg     <= ST_RX;
      cnt_reg       <= '0;
      phase_reg     <= 1'b0;
      lat_reg       <= '0;
      Wr_En         <= 1'b0;
      Wr_Addr       <= IN_A;
      Wr_Data       <= '0;
      Rd_En         <= 1'b0;
      Rd_Addr       <= OUT_A;
      Tx_Data       <= '0;
      Tx_Start      <= 1'b0;
      Host_Owns_Ram <= 1'b1;
      Compute_En    <= 1'b0;
      Frame_Err     <= 1'b0;
      Frame_Cnt     <= '0;
    end else begin
      Wr_En     <= 1'b0;
      Rd_En     <= 1'b0;
      Tx_Start  <= 1'b0;
      Frame_Err <= 1'b0;
      case (state_reg)
        ST_RX: begin
          if (Rx_Valid) begin
            if (!sum_word) begin
              Wr_En   <= 1'b1;
              Wr_Addr <= IN_A + cnt_reg[ADDR_W-1:0];
              Wr_Data <= Rx_Data;
            end
            if (last_rx) begin
              cnt_reg <= '0;
              if (sum_ok) begin
                state_reg <= ST_COMPUTE;
              end else begin
                Frame_Err <= 1'b1;
              end
            end else begin
              cnt_reg <= cnt_reg + 1'b1;
            end
          end else if (tmo_expire) begin
            cnt_reg   <= '0;
            Frame_Err <= 1'b1;
          end
        end
        ST_COMPUTE: begin
          // Hand the RAM over one cycle after the final write has gone out;
          // a Compute_Done still high from the last pass is ignored then.
          if (!Compute_En) begin
            Compute_En    <= 1'b1;
            Host_Owns_Ram <= 1'b0;
          end else if (Compute_Done) begin
            Compute_En    <= 1'b0;
            Host_Owns_Ram <= 1'b1;
            cnt_reg       <= '0;
            phase_reg     <= 1'b0;
            state_reg     <= ST_TX_RD;
          end
        end
        ST_TX_RD: begin
          if (!phase_reg) begin
            Rd_En     <= 1'b1;
            Rd_Addr   <= OUT_A + cnt_reg[ADDR_W-1:0];
            phase_reg <= 1'b1;
            lat_reg   <= '0;
          end else if (lat_reg == 2'(RD_LAT)) begin
            Tx_Data   <= Rd_Data;
            phase_reg <= 1'b0;
            state_reg <= ST_TX_WAIT_IDLE;
          end else begin
            lat_reg <= lat_reg + 1'b1;
          end
        end
        ST_TX_WAIT_IDLE: begin
          if (Tx_Idle) begin
            Tx_Start  <= 1'b1;
            phase_reg <= 1'b0;
            state_reg <= ST_TX_BUSY;
          end
        end
        ST_TX_BUSY: begin
          // A word is done only after the UART has gone busy and idle again.
          if (!phase_reg) begin
            if (!Tx_Idle) begin
              phase_reg <= 1'b1;
            end
          end else if (Tx_Idle) begin
            phase_reg <= 1'b0;
            if (cnt_reg == LAST_OUT) begin
              Frame_Cnt <= Frame_Cnt + 1'b1;
              cnt_reg   <= '0;
              state_reg <= ST_RX;
            end else begin
              cnt_reg   <= cnt_reg + 1'b1;
              state_reg <= ST_TX_RD;
            end
          end
        end
        default: begin
          state_reg <= ST_RX;
          cnt_reg   <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_host_io_sequencer.sv
// tb_host_io_sequencer: scoreboard bench with a RAM, compute-processor and
// UART TX model around host_io_sequencer.
module tb_host_io_sequencer;

  localparam int DATA_W   = 16;
  localparam int ADDR_W   = 10;
  localparam int N_IN     = 8;
  localparam int N_OUT    = 2;
  localparam int IN_BASE  = 0;
  localparam int OUT_BASE = 16;
  localparam int RD_LAT   = 1;
  localparam int TIMEOUT  = 50;

  logic              Clk = 1'b0;
  logic              Rst_n = 1'b0;
  logic              Rx_Valid = 1'b0;
  logic [DATA_W-1:0] Rx_Data = '0;
  logic              Wr_En;
  logic [ADDR_W-1:0] Wr_Addr;
  logic [DATA_W-1:0] Wr_Data;
  logic              Rd_En;
  logic [ADDR_W-1:0] Rd_Addr;
  logic [DATA_W-1:0] Rd_Data;
  logic              Host_Owns_Ram;
  logic              Compute_En;
  logic              Compute_Done = 1'b0;
  logic [DATA_W-1:0] Tx_Data;
  logic              Tx_Start;
  logic              Tx_Idle;
  logic              Frame_Err;
  logic [15:0]       Frame_Cnt;

  always #5 Clk = ~Clk;

  host_io_sequencer #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .N_IN(N_IN), .N_OUT(N_OUT),
    .IN_BASE(IN_BASE), .OUT_BASE(OUT_BASE), .RD_LAT(RD_LAT), .TIMEOUT(TIMEOUT)
  ) dut (
    .Clk(Clk), .Rst_n(Rst_n), .Rx_Valid(Rx_Valid), .Rx_Data(Rx_Data),
    .Wr_En(Wr_En), .Wr_Addr(Wr_Addr), .Wr_Data(Wr_Data),
    .Rd_En(Rd_En), .Rd_Addr(Rd_Addr), .Rd_Data(Rd_Data),
    .Host_Owns_Ram(Host_Owns_Ram), .Compute_En(Compute_En),
    .Compute_Done(Compute_Done), .Tx_Data(Tx_Data), .Tx_Start(Tx_Start),
    .Tx_Idle(Tx_Idle), .Frame_Err(Frame_Err), .Frame_Cnt(Frame_Cnt)
  );

  // Scoreboard state
  logic [ADDR_W+DATA_W-1:0] wr_exp_q[$];
  logic [ADDR_W-1:0]        rd_exp_q[$];
  logic [DATA_W-1:0]        tx_exp_q[$];
  logic [DATA_W-1:0]        res [N_OUT];
  logic [DATA_W-1:0]        mem [1 << ADDR_W];
  logic [DATA_W-1:0]        rd_q = '0;
  logic [DATA_W-1:0]        tx_hold = '0;
  logic [DATA_W-1:0]        xor_acc = '0;
  int  n_checks = 0;
  int  n_fail = 0;
  int  err_seen = 0;
  int  start_seen = 0;
  int  compute_rises = 0;
  int  comp_cnt = 0;
  int  comp_lat = 20;
  int  busy_cnt = 0;
  int  exp_frames = 0;
  bit  force_busy = 1'b0;
  logic comp_prev = 1'b0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic fail_event(input string name, input logic [31:0] got);
    n_checks++;
    n_fail++;
    $display("FAIL %s: unexpected event value 0x%0h expected none at %0t", name, got, $time);
  endtask

  // RAM (registered read) and compute processor: results appear in RAM and
  // in the scoreboard comp_lat cycles after Compute_En rises.
  always @(posedge Clk) begin
    if (Wr_En && Host_Owns_Ram) mem[Wr_Addr] <= Wr_Data;
    if (Rd_En && Host_Owns_Ram) rd_q <= mem[Rd_Addr];
    Compute_Done <= 1'b0;
    if (Compute_En) begin
      comp_cnt <= comp_cnt + 1;
      if (comp_cnt == comp_lat - 1) begin
        for (int j = 0; j < N_OUT; j++) begin
          mem[OUT_BASE + j] <= res[j];
          tx_exp_q.push_back(res[j]);
          rd_exp_q.push_back(ADDR_W'(OUT_BASE + j));
        end
        Compute_Done <= 1'b1;
      end
    end else begin
      comp_cnt <= 0;
    end
  end
  assign Rd_Data = rd_q;

  // UART TX: busy for a few cycles after each start pulse.
  always @(posedge Clk) begin
    if (!Rst_n) busy_cnt <= 0;
    else if (Tx_Start) busy_cnt <= 6;
    else if (busy_cnt != 0) busy_cnt <= busy_cnt - 1;
  end
  assign Tx_Idle = (busy_cnt == 0) && !force_busy;

  // Monitor: compares every DUT output event against the scoreboard queues.
  always @(negedge Clk) begin
    if (Rst_n) begin
      if (Wr_En) begin
        if (wr_exp_q.size() == 0) fail_event("wr_unexpected", 32'(Wr_Addr));
        else begin
          check("wr_addr", 32'(Wr_Addr), 32'(wr_exp_q[0][ADDR_W+DATA_W-1:DATA_W]));
          check("wr_data", 32'(Wr_Data), 32'(wr_exp_q[0][DATA_W-1:0]));
          check("wr_owner", 32'(Host_Owns_Ram), 32'd1);
          $display("write addr=%0d data=0x%04h", Wr_Addr, Wr_Data);
          void'(wr_exp_q.pop_front());
        end
      end
      if (Rd_En) begin
        if (rd_exp_q.size() == 0) fail_event("rd_unexpected", 32'(Rd_Addr));
        else begin
          check("rd_addr", 32'(Rd_Addr), 32'(rd_exp_q[0]));
          void'(rd_exp_q.pop_front());
        end
      end
      if (Tx_Start) begin
        check("tx_start_idle", 32'(Tx_Idle), 32'd1);
        if (tx_exp_q.size() == 0) fail_event("tx_unexpected", 32'(Tx_Data));
        else begin
          check("tx_data", 32'(Tx_Data), 32'(tx_exp_q[0]));
          $display("tx data=0x%04h", Tx_Data);
          void'(tx_exp_q.pop_front());
        end
        tx_hold    <= Tx_Data;
        start_seen <= start_seen + 1;
      end else if (busy_cnt != 0) begin
        check("tx_data_stable", 32'(Tx_Data), 32'(tx_hold));
      end
      if (Frame_Err) begin
        err_seen <= err_seen + 1;
        $display("frame error observed");
      end
      if (Compute_En && !comp_prev) compute_rises <= compute_rises + 1;
      comp_prev <= Compute_En;
    end
  end

  task automatic set_results();
    for (int j = 0; j < N_OUT; j++) res[j] = DATA_W'($urandom);
  endtask

  task automatic send_word(input logic [DATA_W-1:0] d, input bit expect_wr, input int idx);
    @(posedge Clk);
    #1;
    Rx_Valid = 1'b1;
    Rx_Data  = d;
    if (expect_wr) begin
      wr_exp_q.push_back({ADDR_W'(IN_BASE + idx), d});
      xor_acc = xor_acc ^ d;
    end
    @(posedge Clk);
    #1;
    Rx_Valid = 1'b0;
  endtask

  // Sends words first..N_IN-1 of a frame (plus checksum when enabled).
  task automatic send_frame_words(input int first, input bit use_seq);
    logic [DATA_W-1:0] d;
    for (int i = first; i < N_IN; i++) begin
      repeat ($urandom_range(0, 3)) @(posedge Clk);
      d = use_seq ? DATA_W'(16'h1000 + i) : DATA_W'($urandom);
      send_word(d, 1'b1, i);
    end
`ifdef HOST_SEQ_CHECKSUM_EN
    send_word(xor_acc, 1'b0, 0);
`endif
    xor_acc = '0;
  endtask

  task automatic wait_frames(input string name);
    for (int k = 0; k < 3000 && Frame_Cnt !== 16'(exp_frames); k++) @(posedge Clk);
    #1;
    check(name, 32'(Frame_Cnt), 32'(exp_frames));
  endtask

  task automatic wait_compute(input string name, input logic lvl);
    for (int k = 0; k < 3000 && Compute_En !== lvl; k++) @(posedge Clk);
    #1;
    check(name, 32'(Compute_En), 32'(lvl));
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_wr_en"}, 32'(Wr_En), 32'd0);
    check({tag, "_wr_addr"}, 32'(Wr_Addr), 32'(IN_BASE));
    check({tag, "_wr_data"}, 32'(Wr_Data), 32'd0);
    check({tag, "_rd_en"}, 32'(Rd_En), 32'd0);
    check({tag, "_rd_addr"}, 32'(Rd_Addr), 32'(OUT_BASE));
    check({tag, "_tx_data"}, 32'(Tx_Data), 32'd0);
    check({tag, "_tx_start"}, 32'(Tx_Start), 32'd0);
    check({tag, "_owner"}, 32'(Host_Owns_Ram), 32'd1);
    check({tag, "_compute_en"}, 32'(Compute_En), 32'd0);
    check({tag, "_frame_err"}, 32'(Frame_Err), 32'd0);
    check({tag, "_frame_cnt"}, 32'(Frame_Cnt), 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int err0;
    int starts0;
    int comp0;

    // Reset
    repeat (3) @(posedge Clk);
    #1;
    check_reset_values("reset");
    Rst_n = 1'b1;

    // Nominal frame with sequential data
    set_results();
    xor_acc = '0;
    send_frame_words(0, 1'b1);
    exp_frames++;
    wait_frames("nominal_frame_cnt");
    check("nominal_compute_rises", 32'(compute_rises), 32'd1);
    check("nominal_tx_starts", 32'(start_seen), 32'(N_OUT));

    // Timeout after a partial frame
    err0 = err_seen;
    for (int i = 0; i < 3; i++) send_word(DATA_W'($urandom), 1'b1, i);
    xor_acc = '0;
    repeat (TIMEOUT - 1) @(posedge Clk);
    #1;
    check("timeout_not_early", 32'(Frame_Err), 32'd0);
    check("timeout_no_err_yet", 32'(err_seen), 32'(err0));
    @(posedge Clk);
    #1;
    check("timeout_err_pulse", 32'(Frame_Err), 32'd1);
    @(posedge Clk);
    #1;
    check("timeout_err_count", 32'(err_seen), 32'(err0 + 1));
    set_results();
    send_frame_words(0, 1'b0);
    exp_frames++;
    wait_frames("after_timeout_frame_cnt");

    // Word arriving on the expiry cycle wins; words during TX are dropped
    err0 = err_seen;
    set_results();
    for (int i = 0; i < 3; i++) send_word(DATA_W'($urandom), 1'b1, i);
    repeat (TIMEOUT - 2) @(posedge Clk);
    send_word(DATA_W'($urandom), 1'b1, 3);
    send_frame_words(4, 1'b0);
    wait_compute("simul_compute_up", 1'b1);
    wait_compute("simul_compute_down", 1'b0);
    for (int i = 0; i < 3; i++) send_word(DATA_W'($urandom), 1'b0, 0);
    exp_frames++;
    wait_frames("simul_frame_cnt");
    check("simul_no_err", 32'(err_seen), 32'(err0));

    // TX handshake with the UART held busy
    starts0 = start_seen;
    force_busy = 1'b1;
    set_results();
    send_frame_words(0, 1'b0);
    wait_compute("hs_compute_up", 1'b1);
    wait_compute("hs_compute_down", 1'b0);
    repeat (100) @(posedge Clk);
    #1;
    check("hs_no_start_while_busy", 32'(start_seen), 32'(starts0));
    check("hs_pending_words", 32'(tx_exp_q.size()), 32'(N_OUT));
    if (tx_exp_q.size() != 0) check("hs_tx_data_latched", 32'(Tx_Data), 32'(tx_exp_q[0]));
    force_busy = 1'b0;
    exp_frames++;
    wait_frames("hs_frame_cnt");
    check("hs_tx_starts", 32'(start_seen), 32'(starts0 + N_OUT));

    // Reset while compute is running
    comp_lat = 1000;
    comp0 = compute_rises;
    set_results();
    send_frame_words(0, 1'b0);
    wait_compute("rst_compute_up", 1'b1);
    repeat (5) @(posedge Clk);
    #1;
    Rst_n = 1'b0;
    @(posedge Clk);
    #1;
    Rst_n = 1'b1;
    check_reset_values("midrst");
    exp_frames = 0;
    comp_lat = 20;
    set_results();
    send_frame_words(0, 1'b0);
    exp_frames++;
    wait_frames("post_reset_frame_cnt");
    check("post_reset_compute_rises", 32'(compute_rises), 32'(comp0 + 2));

`ifdef HOST_SEQ_CHECKSUM_EN
    // Corrupted checksum: error, no compute, data words still written
    err0 = err_seen;
    comp0 = compute_rises;
    xor_acc = '0;
    for (int i = 0; i < N_IN; i++) send_word(DATA_W'($urandom), 1'b1, i);
    send_word(xor_acc ^ DATA_W'(1), 1'b0, 0);
    xor_acc = '0;
    repeat (5) @(posedge Clk);
    #1;
    check("cksum_bad_err", 32'(err_seen), 32'(err0 + 1));
    check("cksum_bad_no_compute", 32'(compute_rises), 32'(comp0));
    check("cksum_bad_compute_en", 32'(Compute_En), 32'd0);
`endif

    repeat (10) @(posedge Clk);
    #1;
    check("wr_queue_drained", 32'(wr_exp_q.size()), 32'd0);
    check("rd_queue_drained", 32'(rd_exp_q.size()), 32'd0);
    check("tx_queue_drained", 32'(tx_exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/host_io_sequencer.md
Name: host_io_sequencer

Overview:
- Top-level frame sequencer between the UART RX/TX flow controllers, Data_RAM and Compute_Processor.
- Receives a parametrised number of input words into RAM, runs one compute pass, then streams a parametrised number of result words back out.
- Successor to the fixed 512-in/1-out single-shot sequencer, adding:
  - synchronous reset;
  - a per-word address counter with a configurable base;
  - multi-word TX with a proper idle handshake;
  - frame-abort timeout with an error flag;
  - a frame counter.

Parameters:
- DATA_W, 16, RAM/UART word width.
- ADDR_W, 10, RAM address width.
- N_IN, 512, input words per frame (1..2**ADDR_W).
- N_OUT, 4, output words per frame (1..2**ADDR_W).
- IN_BASE, 0, RAM address of the first input word.
- OUT_BASE, 512, RAM address of the first output word.
- RD_LAT, 1, RAM read latency in cycles (0..3).
- TIMEOUT, 12500, idle cycles allowed between RX words inside a frame.

Ports:
- Clk  in  1  system clock
- Rst_n  in  1  synchronous active-low reset
- Rx_Valid  in  1  one-cycle pulse: new word on Rx_Data
- Rx_Data  in  DATA_W  received word
- Wr_En  out  1  RAM write strobe
- Wr_Addr  out  ADDR_W  RAM write address
- Wr_Data  out  DATA_W  RAM write data
- Rd_En  out  1  RAM read strobe (TX path)
- Rd_Addr  out  ADDR_W  RAM read address (TX path)
- Rd_Data  in  DATA_W  RAM read data, valid RD_LAT cycles after Rd_En
- Host_Owns_Ram  out  1  1 = RAM ports driven by this block, 0 = Compute_Processor
- Compute_En  out  1  level enable to Compute_Processor
- Compute_Done  in  1  compute finished (level or pulse)
- Tx_Data  out  DATA_W  word to UART TX
- Tx_Start  out  1  one-cycle start pulse to UART TX
- Tx_Idle  in  1  UART TX idle
- Frame_Err  out  1  one-cycle pulse on frame abort
- Frame_Cnt  out  16  completed frames, wraps at 2**16

Behaviour:
- Reset (Rst_n=0 at a Clk edge):
  - state=RX, word counter=0.
  - All strobes 0: Wr_En, Rd_En, Tx_Start, Compute_En, Frame_Err.
  - Wr_Addr=IN_BASE, Wr_Data=0, Rd_Addr=OUT_BASE, Tx_Data=0, Host_Owns_Ram=1, Frame_Cnt=0.
  - Reset in any state, including mid-compute or mid-TX, returns to exactly these values the next cycle.
- States: RX -> COMPUTE -> TX_RD -> TX_WAIT_IDLE -> TX_BUSY -> back to TX_RD or RX.
- RX:
  - On Rx_Valid: Wr_En=1, Wr_Addr=IN_BASE+cnt, Wr_Data=Rx_Data, all registered (one-cycle latency from Rx_Valid); cnt++; idle timer cleared.
  - After the word with cnt==N_IN-1 is written, go to COMPUTE.
  - Idle timer:
    - counts only when cnt>0 and Rx_Valid=0;
    - at TIMEOUT: cnt=0, timer=0, Frame_Err pulse, stay in RX;
    - Rx_Valid in the same cycle as expiry wins (word accepted, no error).
  - Wr_En is otherwise 0.
- COMPUTE:
  - Host_Owns_Ram=0 and Compute_En=1 from the first cycle.
  - On Compute_Done=1: Compute_En=0, Host_Owns_Ram=1, cnt=0, go to TX_RD.
  - Rx_Valid in COMPUTE or any TX state is ignored; the word is lost and no error is raised.
- TX_RD:
  - Rd_En pulse with Rd_Addr=OUT_BASE+cnt.
  - Wait RD_LAT cycles, then latch Rd_Data into Tx_Data and go to TX_WAIT_IDLE.
- TX_WAIT_IDLE: when Tx_Idle=1, pulse Tx_Start for exactly one cycle and go to TX_BUSY.
- TX_BUSY:
  - Wait for Tx_Idle=0, then Tx_Idle=1; Tx_Data is held stable throughout.
  - Then, if cnt==N_OUT-1: Frame_Cnt++, cnt=0, go to RX. Otherwise cnt++ and go to TX_RD.
- Address arithmetic is modulo 2**ADDR_W.
- Tx_Start is never asserted while Tx_Idle=0.

Optional Feature:
- Macro: HOST_SEQ_CHECKSUM_EN.
- Defined:
  - RX expects N_IN+1 words; the last word is the XOR of the N_IN data words and is not written to RAM.
  - Mismatch: Frame_Err pulse, cnt=0, stay in RX (no compute).
  - The running XOR also clears on timeout and on reset.
- Undefined: N_IN words, no check, no checksum logic synthesised.

Decomposition:
- Shared package host_io_pkg holds:
  - state encoding typedef (one-hot, 5 states);
  - default widths DATA_W/ADDR_W;
  - the IN_BASE/OUT_BASE constants, shared with Data_RAM users.
- One natural sub-module, host_rx_timeout: idle timer with clear/expire, parametrised by TIMEOUT.

Test Plan:
- Nominal frame: N_IN=8, N_OUT=2, IN_BASE=0, OUT_BASE=16, RD_LAT=1; send words 0x1000..0x1007 -> writes at addresses 0..7 in order, Compute_En rises after the 8th write. Compute_Done after 20 cycles -> reads at 16 and 17, two Tx_Start pulses, Tx_Data equal to RAM contents, Frame_Cnt=1.
- Timeout: TIMEOUT=50; send 3 words, then silence for 50 cycles -> Frame_Err pulse. A full 8-word frame afterwards writes starting again at address 0.
- TX handshake: hold Tx_Idle=0 for 100 cycles before the first word -> no Tx_Start until Tx_Idle=1, Tx_Data stable throughout, and exactly N_OUT pulses total.
- Reset mid-compute: Rst_n=0 for 1 cycle while Compute_En=1 -> next cycle Compute_En=0, Host_Owns_Ram=1, state RX, Frame_Cnt=0.
- Simultaneous events: Rx_Valid on the timeout-expiry cycle -> word written, no Frame_Err. Rx_Valid during TX -> no RAM write.
- HOST_SEQ_CHECKSUM_EN defined: 8 words plus a correct XOR -> compute runs. A corrupted checksum -> Frame_Err, no Compute_En, only 8 writes.
